// File: rtl/td4_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : td4_sequencer
// Description : TD4 fetch/decode/execute sequencer with run/step/halt control,
//               breakpoint and programmable inter-instruction tick divider.
//               opecode encoding: 0-7 per raw opcode 0000-0111, 8 OUT_B,
//               9 OUT_IMM, 10 JNC_IMM, 11 JMP_IMM, 15 INVALID.
// Revision    : 1.0 - initial release
// ============================================================================
module td4_sequencer #(
    parameter int TICK_DIV = 4,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic             step,
    input  logic             halt,
    input  logic             bp_en,
    input  logic [3:0]       bp_addr,
    input  logic [3:0]       pc,
    output logic [3:0]       rom_addr,
    input  logic [7:0]       rom_data,
    output logic [3:0]       opecode,
    output logic [3:0]       imm,
    output logic             alu_en,
    output logic             busy,
    output logic             halted,
    output logic             bp_hit,
    output logic [CNT_W-1:0] instr_count
);

    localparam logic [2:0] c_ST_HALT   = 3'd0;
    localparam logic [2:0] c_ST_WAIT   = 3'd1;
    localparam logic [2:0] c_ST_FETCH  = 3'd2;
    localparam logic [2:0] c_ST_DECODE = 3'd3;
    localparam logic [2:0] c_ST_EXEC   = 3'd4;
    localparam logic [2:0] c_ST_RETIRE = 3'd5;

    localparam logic [3:0] c_OP_ADD_A_IMM = 4'd0;
    localparam logic [3:0] c_OP_MOV_A_B   = 4'd1;
    localparam logic [3:0] c_OP_IN_A      = 4'd2;
    localparam logic [3:0] c_OP_MOV_A_IMM = 4'd3;
    localparam logic [3:0] c_OP_MOV_B_A   = 4'd4;
    localparam logic [3:0] c_OP_ADD_B_IMM = 4'd5;
    localparam logic [3:0] c_OP_IN_B      = 4'd6;
    localparam logic [3:0] c_OP_MOV_B_IMM = 4'd7;
    localparam logic [3:0] c_OP_OUT_B     = 4'd8;
    localparam logic [3:0] c_OP_OUT_IMM   = 4'd9;
    localparam logic [3:0] c_OP_JNC_IMM   = 4'd10;
    localparam logic [3:0] c_OP_JMP_IMM   = 4'd11;
    localparam logic [3:0] c_OP_INVALID   = 4'd15;

    localparam logic [15:0] c_TICK_LAST = 16'(TICK_DIV - 1);

    logic [2:0]       r_state;
    logic [2:0]       w_state_nxt;
    logic [15:0]      r_tick;
    logic             r_pend_halt;
    logic             r_resume_skip;
    logic             r_step_mode;
    logic             r_bp_hit;
    logic [3:0]       r_opecode;
    logic [3:0]       r_imm;
    logic             r_alu_en;
    logic             r_busy;
    logic             r_halted;
    logic [CNT_W-1:0] r_instr_count;
    logic             w_bp_match;
    logic             w_alu_en_nxt;
    logic             w_busy_nxt;
    logic             w_halted_nxt;
    logic [3:0]       w_op_dec;

    assign w_bp_match = bp_en && (pc == bp_addr) && !r_resume_skip;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_ST_HALT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_HALT: begin
                if (!halt) begin
                    if (step) begin
                        w_state_nxt = c_ST_FETCH;
                    end else if (run) begin
                        w_state_nxt = c_ST_WAIT;
                    end
                end
            end
            c_ST_WAIT: begin
                if (r_pend_halt || halt || !run) begin
                    w_state_nxt = c_ST_HALT;
                end else if (r_tick == c_TICK_LAST) begin
                    w_state_nxt = c_ST_FETCH;
                end
            end
            c_ST_FETCH:  w_state_nxt = w_bp_match ? c_ST_HALT : c_ST_DECODE;
            c_ST_DECODE: w_state_nxt = c_ST_EXEC;
            c_ST_EXEC:   w_state_nxt = c_ST_RETIRE;
            c_ST_RETIRE: begin
                // A halt arriving in the retire cycle itself is honoured directly.
                if (r_pend_halt || halt || (r_step_mode && !run)) begin
                    w_state_nxt = c_ST_HALT;
                end else begin
                    w_state_nxt = c_ST_WAIT;
                end
            end
            default: w_state_nxt = c_ST_HALT;
        endcase
    end

    always_comb begin
        w_alu_en_nxt = (w_state_nxt == c_ST_EXEC);
        w_halted_nxt = (w_state_nxt == c_ST_HALT);
        w_busy_nxt   = (w_state_nxt == c_ST_FETCH) || (w_state_nxt == c_ST_DECODE) ||
                       (w_state_nxt == c_ST_EXEC)  || (w_state_nxt == c_ST_RETIRE);
    end

    always_comb begin
        w_op_dec = c_OP_INVALID;
        case (rom_data[7:4])
            4'b0000: w_op_dec = c_OP_ADD_A_IMM;
            4'b0001: w_op_dec = c_OP_MOV_A_B;
            4'b0010: w_op_dec = c_OP_IN_A;
            4'b0011: w_op_dec = c_OP_MOV_A_IMM;
            4'b0100: w_op_dec = c_OP_MOV_B_A;
            4'b0101: w_op_dec = c_OP_ADD_B_IMM;
            4'b0110: w_op_dec = c_OP_IN_B;
            4'b0111: w_op_dec = c_OP_MOV_B_IMM;
            4'b1001: w_op_dec = c_OP_OUT_B;
            4'b1011: w_op_dec = c_OP_OUT_IMM;
            4'b1110: w_op_dec = c_OP_JNC_IMM;
            4'b1111: w_op_dec = c_OP_JMP_IMM;
            default: w_op_dec = c_OP_INVALID;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tick        <= 16'd0;
            r_pend_halt   <= 1'b0;
            r_resume_skip <= 1'b0;
            r_step_mode   <= 1'b0;
            r_bp_hit      <= 1'b0;
            r_opecode     <= c_OP_INVALID;
            r_imm         <= 4'd0;
            r_alu_en      <= 1'b0;
            r_busy        <= 1'b0;
            r_halted      <= 1'b1;
            r_instr_count <= '0;
        end else begin
            r_alu_en <= w_alu_en_nxt;
            r_busy   <= w_busy_nxt;
            r_halted <= w_halted_nxt;

            if ((r_state == c_ST_WAIT) && (w_state_nxt == c_ST_WAIT)) begin
                r_tick <= r_tick + 16'd1;
            end else begin
                r_tick <= 16'd0;
            end

            if (w_state_nxt == c_ST_HALT) begin
                r_pend_halt <= 1'b0;
            end else if (halt && r_busy) begin
                r_pend_halt <= 1'b1;
            end

            if ((r_state == c_ST_HALT) && (w_state_nxt != c_ST_HALT)) begin
                r_resume_skip <= 1'b1;
                r_bp_hit      <= 1'b0;
            end else begin
                if (r_state == c_ST_RETIRE) begin
                    r_resume_skip <= 1'b0;
                end
                if ((r_state == c_ST_FETCH) && w_bp_match) begin
                    r_bp_hit <= 1'b1;
                end
            end

            // Remembers whether the instruction now starting was launched by step.
            if (w_state_nxt == c_ST_FETCH) begin
                r_step_mode <= (r_state == c_ST_HALT);
            end

            if (r_state == c_ST_DECODE) begin
                r_opecode <= w_op_dec;
                r_imm     <= rom_data[3:0];
            end

            if (r_state == c_ST_EXEC) begin
                r_instr_count <= r_instr_count + CNT_W'(1);
            end
        end
    end

    assign rom_addr    = (r_state == c_ST_FETCH) ? pc : 4'd0;
    assign opecode     = r_opecode;
    assign imm         = r_imm;
    assign alu_en      = r_alu_en;
    assign busy        = r_busy;
    assign halted      = r_halted;
    assign bp_hit      = r_bp_hit;
    assign instr_count = r_instr_count;

endmodule
`default_nettype wire

// File: tb/tb_td4_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_td4_sequencer
// Description : Self-checking bench for td4_sequencer with ROM/ALU environment.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_td4_sequencer;

    localparam int TICK_DIV = 4;

    localparam logic [3:0] OP_ADD_A_IMM = 4'd0;
    localparam logic [3:0] OP_MOV_A_B   = 4'd1;
    localparam logic [3:0] OP_IN_A      = 4'd2;
    localparam logic [3:0] OP_MOV_A_IMM = 4'd3;
    localparam logic [3:0] OP_MOV_B_A   = 4'd4;
    localparam logic [3:0] OP_ADD_B_IMM = 4'd5;
    localparam logic [3:0] OP_IN_B      = 4'd6;
    localparam logic [3:0] OP_MOV_B_IMM = 4'd7;
    localparam logic [3:0] OP_OUT_B     = 4'd8;
    localparam logic [3:0] OP_OUT_IMM   = 4'd9;
    localparam logic [3:0] OP_JNC_IMM   = 4'd10;
    localparam logic [3:0] OP_JMP_IMM   = 4'd11;
    localparam logic [3:0] OP_INVALID   = 4'd15;

    localparam int M_HALTED = 0;
    localparam int M_WAIT   = 1;
    localparam int M_INSTR  = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        run = 1'b0, step = 1'b0, halt = 1'b0, bp_en = 1'b0;
    logic [3:0]  bp_addr = 4'd0;
    logic [3:0]  pc;
    logic [3:0]  rom_addr, opecode, imm;
    logic [7:0]  rom_data = 8'd0;
    logic        alu_en, busy, halted, bp_hit;
    logic [15:0] instr_count;
    logic [3:0]  rom_addr2, opecode2, imm2, instr_count2;
    logic        alu_en2, busy2, halted2, bp_hit2;
    logic [7:0]  rom [16];
    logic [3:0]  cpu_a, cpu_b, cpu_out;
    logic        cpu_cf;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    td4_sequencer #(.TICK_DIV(TICK_DIV), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .run(run), .step(step), .halt(halt), .bp_en(bp_en),
        .bp_addr(bp_addr), .pc(pc), .rom_addr(rom_addr), .rom_data(rom_data),
        .opecode(opecode), .imm(imm), .alu_en(alu_en), .busy(busy), .halted(halted),
        .bp_hit(bp_hit), .instr_count(instr_count)
    );

    // Narrow counter copy so that the wrap-around is reachable in a short run.
    td4_sequencer #(.TICK_DIV(TICK_DIV), .CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .run(run), .step(step), .halt(halt), .bp_en(bp_en),
        .bp_addr(bp_addr), .pc(pc), .rom_addr(rom_addr2), .rom_data(rom_data),
        .opecode(opecode2), .imm(imm2), .alu_en(alu_en2), .busy(busy2), .halted(halted2),
        .bp_hit(bp_hit2), .instr_count(instr_count2)
    );

    always @(posedge clk) rom_data <= rom[rom_addr];

    // TD4 register file / ALU, updated by the execute strobe.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            cpu_a <= 4'd0; cpu_b <= 4'd0; cpu_out <= 4'd0; cpu_cf <= 1'b0; pc <= 4'd0;
        end else if (alu_en) begin
            pc     <= pc + 4'd1;
            cpu_cf <= 1'b0;
            case (opecode)
                OP_ADD_A_IMM: {cpu_cf, cpu_a} <= {1'b0, cpu_a} + {1'b0, imm};
                OP_MOV_A_B:   cpu_a <= cpu_b;
                OP_IN_A:      cpu_a <= 4'd0;
                OP_MOV_A_IMM: cpu_a <= imm;
                OP_MOV_B_A:   cpu_b <= cpu_a;
                OP_ADD_B_IMM: {cpu_cf, cpu_b} <= {1'b0, cpu_b} + {1'b0, imm};
                OP_IN_B:      cpu_b <= 4'd0;
                OP_MOV_B_IMM: cpu_b <= imm;
                OP_OUT_B:     cpu_out <= cpu_b;
                OP_OUT_IMM:   cpu_out <= imm;
                OP_JNC_IMM:   if (!cpu_cf) pc <= imm;
                OP_JMP_IMM:   pc <= imm;
                default: ;
            endcase
        end
    end

    function automatic logic [3:0] op_of(input logic [3:0] raw);
        case (raw)
            4'h0: return OP_ADD_A_IMM;
            4'h1: return OP_MOV_A_B;
            4'h2: return OP_IN_A;
            4'h3: return OP_MOV_A_IMM;
            4'h4: return OP_MOV_B_A;
            4'h5: return OP_ADD_B_IMM;
            4'h6: return OP_IN_B;
            4'h7: return OP_MOV_B_IMM;
            4'h9: return OP_OUT_B;
            4'hB: return OP_OUT_IMM;
            4'hE: return OP_JNC_IMM;
            4'hF: return OP_JMP_IMM;
            default: return OP_INVALID;
        endcase
    endfunction

    // Reference model: halted / waiting / executing, with a phase index
    // 0..3 counting cycles since the instruction was fetched.
    int          m_mode, m_phase, m_wait;
    bit          m_pend, m_skip, m_via_step, m_bp;
    int unsigned m_count;
    logic [3:0]  m_op, m_imm, m_fetch_pc;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_mode <= M_HALTED; m_phase <= 0; m_wait <= 0; m_pend <= 1'b0; m_skip <= 1'b0;
            m_via_step <= 1'b0; m_bp <= 1'b0; m_count <= 0; m_op <= OP_INVALID;
            m_imm <= 4'd0; m_fetch_pc <= 4'd0;
        end else begin
            case (m_mode)
                M_HALTED: begin
                    if (!halt && (step || run)) begin
                        m_skip <= 1'b1; m_bp <= 1'b0; m_via_step <= step;
                        m_mode <= step ? M_INSTR : M_WAIT;
                        m_phase <= 0; m_wait <= 0;
                    end
                end
                M_WAIT: begin
                    if (m_pend || halt || !run) begin
                        m_mode <= M_HALTED; m_pend <= 1'b0;
                    end else if (m_wait == TICK_DIV - 1) begin
                        m_mode <= M_INSTR; m_phase <= 0; m_via_step <= 1'b0;
                    end else begin
                        m_wait <= m_wait + 1;
                    end
                end
                default: begin
                    if (halt && m_phase < 3) m_pend <= 1'b1;
                    case (m_phase)
                        0: begin
                            if (bp_en && pc == bp_addr && !m_skip) begin
                                m_bp <= 1'b1; m_mode <= M_HALTED; m_pend <= 1'b0;
                            end else begin
                                m_fetch_pc <= pc; m_phase <= 1;
                            end
                        end
                        1: begin
                            m_op  <= op_of(rom[m_fetch_pc][7:4]);
                            m_imm <= rom[m_fetch_pc][3:0];
                            m_phase <= 2;
                        end
                        2: begin
                            m_count <= m_count + 1; m_phase <= 3;
                        end
                        default: begin
                            m_skip <= 1'b0;
                            if (m_pend || halt || (m_via_step && !run)) begin
                                m_mode <= M_HALTED; m_pend <= 1'b0;
                            end else begin
                                m_mode <= M_WAIT; m_wait <= 0;
                            end
                        end
                    endcase
                end
            endcase
        end
    end

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        check("cyc_alu_en",   alu_en,      (m_mode == M_INSTR && m_phase == 2) ? 1 : 0);
        check("cyc_busy",     busy,        (m_mode == M_INSTR) ? 1 : 0);
        check("cyc_halted",   halted,      (m_mode == M_HALTED) ? 1 : 0);
        check("cyc_rom_addr", rom_addr,    (m_mode == M_INSTR && m_phase == 0) ? int'(pc) : 0);
        check("cyc_bp_hit",   bp_hit,      m_bp);
        check("cyc_opecode",  opecode,     m_op);
        check("cyc_imm",      imm,         m_imm);
        check("cyc_count",    instr_count, m_count % 65536);
        check("cyc_count4",   instr_count2, m_count % 16);
    end

    task automatic reset_all();
        run = 1'b0; step = 1'b0; halt = 1'b0; bp_en = 1'b0; bp_addr = 4'd0;
        for (int i = 0; i < 16; i++) rom[i] = 8'h00;
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic pulse_step();
        step = 1'b1;
        @(negedge clk);
        step = 1'b0;
    endtask

    task automatic wait_halted(input int limit, output int pulses);
        int n;
        n = 0;
        pulses = 0;
        while (!halted && n < limit) begin
            @(negedge clk);
            n++;
            if (alu_en) pulses++;
        end
        if (!halted) check("timeout_halted", 0, 1);
    endtask

    task automatic run_n(input int count, input int limit, output int got);
        int cyc, last;
        got = 0; cyc = 0; last = 0;
        run = 1'b1;
        while (got < count && cyc < limit) begin
            @(negedge clk);
            cyc++;
            if (alu_en) begin
                got++;
                if (got > 1) check("run_period", cyc - last, TICK_DIV + 4);
                last = cyc;
            end
        end
        run = 1'b0;
    endtask

    task automatic load_loop_prog();
        rom[0] = 8'h33;  // MOV A,3
        rom[1] = 8'h01;  // ADD A,1
        rom[2] = 8'hF1;  // JMP 1
    endtask

    initial begin
        int p, got;
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int p, got, n;
        for (int i = 0; i < 16; i++) rom[i] = 8'h00;
        @(negedge clk);
        check("rst_halted",  halted, 1);
        check("rst_opecode", opecode, OP_INVALID);
        check("rst_alu_en",  alu_en, 0);
        check("rst_busy",    busy, 0);
        check("rst_count",   instr_count, 0);
        reset_all();

        // Single step: MOV A,3
        rom[0] = 8'h33;
        pulse_step();
        check("step_busy", busy, 1);
        check("step_rom_addr", rom_addr, 0);
        @(negedge clk);
        check("step_decode_alu", alu_en, 0);
        @(negedge clk);
        check("step_alu_en", alu_en, 1);
        check("step_opecode", opecode, OP_MOV_A_IMM);
        check("step_imm", imm, 3);
        @(negedge clk);
        check("step_alu_drop", alu_en, 0);
        check("step_count", instr_count, 1);
        @(negedge clk);
        check("step_halted", halted, 1);
        check("step_cpu_a", cpu_a, 3);

        // Invalid opcode executes as a NOP but still counts
        reset_all();
        rom[0] = 8'h8A;
        pulse_step();
        @(negedge clk);
        @(negedge clk);
        check("inv_alu_en", alu_en, 1);
        check("inv_opecode", opecode, OP_INVALID);
        check("inv_imm", imm, 10);
        wait_halted(20, p);
        check("inv_count", instr_count, 1);
        check("inv_pc", pc, 1);

        // Run cadence
        reset_all();
        load_loop_prog();
        run_n(10, 400, got);
        check("run_pulses", got, 10);
        wait_halted(50, p);
        check("run_count", instr_count, 10);
        check("run_cpu_a", cpu_a, 8);

        // Counter wrap on the 4-bit copy
        reset_all();
        load_loop_prog();
        run_n(17, 400, got);
        wait_halted(50, p);
        check("wrap_count16", instr_count, 17);
        check("wrap_count4", instr_count2, 1);

        // Breakpoint at pc 2
        reset_all();
        load_loop_prog();
        bp_en = 1'b1; bp_addr = 4'd2; run = 1'b1;
        n = 0; p = 0;
        while (!bp_hit && n < 100) begin
            @(negedge clk);
            n++;
            if (alu_en) p++;
        end
        run = 1'b0;
        check("bp_hit", bp_hit, 1);
        check("bp_halted", halted, 1);
        check("bp_pulses", p, 2);
        check("bp_count", instr_count, 2);
        check("bp_pc", pc, 2);
        repeat (3) @(negedge clk);
        check("bp_stays", halted, 1);
        pulse_step();
        check("bp_clear", bp_hit, 0);
        wait_halted(20, p);
        check("bp_step_pulses", p, 1);
        check("bp_step_count", instr_count, 3);
        check("bp_step_pc", pc, 1);
        check("bp_no_retrigger", bp_hit, 0);
        bp_en = 1'b0;

        // Halt outranks a simultaneous step during DECODE
        reset_all();
        rom[0] = 8'h33;
        pulse_step();
        @(negedge clk);
        halt = 1'b1; step = 1'b1; run = 1'b1;
        @(negedge clk);
        halt = 1'b0; step = 1'b0;
        check("hp_alu_en", alu_en, 1);
        wait_halted(20, p);
        run = 1'b0;
        check("hp_count", instr_count, 1);
        p = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (alu_en) p++;
        end
        check("hp_no_more", p, 0);
        check("hp_halted", halted, 1);

        // Asynchronous reset in the middle of EXEC
        reset_all();
        rom[0] = 8'h35;
        pulse_step();
        @(negedge clk);
        @(negedge clk);
        check("ar_pre_alu", alu_en, 1);
        #2 rst = 1'b1;
        #1;
        check("ar_alu_en", alu_en, 0);
        check("ar_halted", halted, 1);
        check("ar_opecode", opecode, OP_INVALID);
        check("ar_count", instr_count, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
